// File: rtl/uart_pkg.sv
// Shared types, oversampling constants and divisor helper for the UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int uart_div(input longint clk_hz, input longint baud);
        longint den;
        den = baud * OVERSAMPLE;
        return int'((clk_hz + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks, re-phased by clear.
module uart_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x majority-vote deframer, one-entry
// valid/ready output buffer, single-cycle framing and overrun pulses.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overrun_err
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);

    if (DIV < 1) begin : g_div_check
        $error("uart_byte_rx: CLK_HZ too low for BAUD, divisor < 1");
    end

    localparam logic [3:0] T_LO   = 4'(SAMPLE_LO);
    localparam logic [3:0] T_MID  = 4'(SAMPLE_MID);
    localparam logic [3:0] T_HI   = 4'(SAMPLE_HI);
    localparam logic [3:0] T_LAST = 4'(OVERSAMPLE - 1);

    logic      sync1_q, rxs_q, rxs_prev_q;
    rx_state_t state_q, state_d;
    logic [3:0] tidx_q, tidx_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       oerr_q, oerr_d;

    logic tick, tick_clear, majority, at_decide, at_end, commit;

    uart_tick_gen #(.DIV(DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    assign majority  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    assign at_decide = tick && (tidx_q == T_HI);
    assign at_end    = tick && (tidx_q == T_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        tidx_d     = tidx_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        tick_clear = 1'b0;
        commit     = 1'b0;
        ferr_d     = 1'b0;

        if (tick && tidx_q == T_LO)  samp_d[0] = rxs_q;
        if (tick && tidx_q == T_MID) samp_d[1] = rxs_q;
        if (tick && state_q inside {START, DATA, STOP}) tidx_d = tidx_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d    = START;
                    tidx_d     = '0;
                    tick_clear = 1'b1;
                end
            end
            START: begin
                if (at_decide && majority) begin
                    state_d = IDLE;
                end else if (at_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (at_decide) shift_d[bit_q] = majority;
                if (at_end) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                // Leave mid stop bit so a slightly fast sender's next start edge is seen.
                if (at_decide) begin
                    if (majority) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        oerr_d  = 1'b0;
        if (commit) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                oerr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
        if (reset) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= IDLE;
            tidx_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            samp_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            oerr_q     <= 1'b0;
        end else begin
            sync1_q    <= rx_serial;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            tidx_q     <= tidx_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            oerr_q     <= oerr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign framing_err = ferr_q;
    assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed scenarios plus random frames,
// scored against a byte-queue model of what a correct receiver must deliver.
module tb_uart_byte_rx;

    localparam int CLK_HZ  = 1_600_000;
    localparam int BAUD    = 100_000;
    localparam int BIT_CYC = 16;
    localparam int FRAME   = 10 * BIT_CYC;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_serial;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    int fe_cnt = 0;
    int oe_cnt = 0;
    int valid_cycles = 0;
    int rise_step = 0;
    int step_n = 0;
    int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

    uart_byte_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_serial   (rx_serial),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rx, input logic force_rdy);
        @(posedge clock);
        #1;
        rx_serial = rx;
        if (force_rdy)          rx_ready = 1'b1;
        else if (rdy_mode == 2) rx_ready = ($urandom_range(0, 3) != 0);
        else                    rx_ready = (rdy_mode == 1);
        step_n++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0);
    endtask

    // Drives the first ncyc cycles of an 8N1 frame; rx_ready forced high at cycle pulse_at.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pulse_at, input int ncyc);
        logic v;
        int   k;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : b[i-1];
            for (int j = 0; j < BIT_CYC; j++) begin
                if (k < ncyc) step(v, k == pulse_at);
                k++;
            end
        end
    endtask

    // Consumer-side model: each handshake must deliver the oldest expected byte;
    // a stalled buffer must hold its byte unchanged.
    initial begin : monitor
        logic [7:0] last_data;
        logic       last_hold;
        logic       prev_valid;
        last_hold  = 1'b0;
        prev_valid = 1'b0;
        last_data  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                last_hold  = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (last_hold) begin
                    check("stall_valid", rx_valid, 1);
                    check("stall_data", rx_data, last_data);
                end
                if (rx_valid) valid_cycles++;
                if (rx_valid && !prev_valid) rise_step = step_n;
                if (framing_err) fe_cnt++;
                if (overrun_err) oe_cnt++;
                if (rx_valid && rx_ready) begin
                    check("byte_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("rx_data", rx_data, exp_q.pop_front());
                end
                last_hold  = rx_valid && !rx_ready;
                last_data  = rx_data;
                prev_valid = rx_valid;
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int v0, f0, o0, s0, lat, nbad;
        logic [7:0] b;
        logic       bad;

        reset     = 1'b1;
        rx_serial = 1'b1;
        rx_ready  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_data", rx_data, 8'h00);
        check("reset_valid", rx_valid, 0);
        check("reset_ferr", framing_err, 0);
        check("reset_oerr", overrun_err, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle line
        rdy_mode = 1;
        v0 = valid_cycles; f0 = fe_cnt; o0 = oe_cnt;
        idle(100);
        check("idle_valid", valid_cycles - v0, 0);
        check("idle_ferr", fe_cnt - f0, 0);
        check("idle_oerr", oe_cnt - o0, 0);

        // 0xA5 with ready held high: one-cycle valid pulse at ~156 cycles
        v0 = valid_cycles; f0 = fe_cnt;
        exp_q.push_back(8'hA5);
        s0 = step_n;
        send_frame(8'hA5, 1'b1, -1, FRAME);
        idle(10);
        lat = rise_step - s0 - 1;
        check("a5_latency", (lat >= 155 && lat <= 157) ? 156 : lat, 156);
        check("a5_received", exp_q.size(), 0);
        check("a5_valid_cycles", valid_cycles - v0, 1);
        check("a5_ferr", fe_cnt - f0, 0);

        // Short low glitch: false start
        v0 = valid_cycles; f0 = fe_cnt;
        repeat (4) step(1'b0, 1'b0);
        idle(40);
        check("glitch_valid", valid_cycles - v0, 0);
        check("glitch_ferr", fe_cnt - f0, 0);

        // Bad stop bit followed by a held break, then a good byte
        v0 = valid_cycles; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, -1, FRAME);
        repeat (64) step(1'b0, 1'b0);
        check("break_valid", valid_cycles - v0, 0);
        idle(20);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1, FRAME);
        idle(10);
        check("break_ferr_once", fe_cnt - f0, 1);
        check("after_break_81", exp_q.size(), 0);
        check("after_break_valid", valid_cycles - v0, 1);

        // Overrun: stalled consumer, two back-to-back bytes
        rdy_mode = 0;
        o0 = oe_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, FRAME);
        send_frame(8'h22, 1'b1, -1, FRAME);
        idle(10);
        @(negedge clock);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_pulse_once", oe_cnt - o0, 1);
        rdy_mode = 1;
        idle(5);
        check("ovr_drained", exp_q.size(), 0);
        @(negedge clock);
        check("ovr_valid_clear", rx_valid, 0);

        // Reset during data bit 4 of 0x55; sender abandons the frame too
        v0 = valid_cycles; f0 = fe_cnt; o0 = oe_cnt;
        send_frame(8'h55, 1'b1, -1, 5 * BIT_CYC + 8);
        @(posedge clock);
        #1;
        reset     = 1'b1;
        rx_serial = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(40);
        check("rst_valid", valid_cycles - v0, 0);
        check("rst_ferr", fe_cnt - f0, 0);
        check("rst_oerr", oe_cnt - o0, 0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, -1, FRAME);
        idle(10);
        check("rst_then_0f", exp_q.size(), 0);

        // Ready asserted exactly in the commit cycle of a byte arriving at a full buffer
        rdy_mode = 0;
        o0 = oe_cnt;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, -1, FRAME);
        idle(8);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 156, FRAME);
        idle(4);
        @(negedge clock);
        check("commit_ready_no_ovr", oe_cnt - o0, 0);
        check("commit_ready_valid", rx_valid, 1);
        check("commit_ready_data", rx_data, 8'hC3);
        check("commit_ready_pending", exp_q.size(), 1);
        rdy_mode = 1;
        idle(5);
        check("commit_ready_drained", exp_q.size(), 0);

        // Random frames, random gaps, random consumer stalls
        rdy_mode = 2;
        f0 = fe_cnt; o0 = oe_cnt;
        nbad = 0;
        for (int n = 0; n < 12; n++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            if (bad) nbad++;
            else     exp_q.push_back(b);
            send_frame(b, !bad, -1, FRAME);
            idle(bad ? $urandom_range(4, 12) : $urandom_range(0, 8));
        end
        rdy_mode = 1;
        idle(40);
        check("rand_all_received", exp_q.size(), 0);
        check("rand_ferr", fe_cnt - f0, nbad);
        check("rand_oerr", oe_cnt - o0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial receive front end that turns the FPGA `uart_rx` pin into bytes for the debug harness command parser.
- Synchronises the asynchronous line and oversamples it 16x.
- Deframes 8N1 characters, LSB first, and presents each byte on a one-entry valid/ready buffer.
- Flags framing and overrun errors as single-cycle pulses.

Parameters:
- CLK_HZ, 100_000_000, frequency of `clock` in Hz.
- BAUD, 115200, line rate in bit/s.
- Derived tick divisor DIV = round(CLK_HZ / (BAUD*16)).
- Elaboration fails if DIV < 1.

Ports:
- clock  in  1  system clock (clk100 domain).
- reset  in  1  synchronous, active-high reset.
- rx_serial  in  1  asynchronous UART line; idles high.
- rx_data  out  8  received byte; valid only while rx_valid=1.
- rx_valid  out  1  buffer holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- framing_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun_err  out  1  one-cycle pulse: completed byte dropped because the buffer was full.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, framing_err=0, overrun_err=0. Both synchroniser flops reset to 1. FSM goes to IDLE. Tick counter and bit counters go to 0.
- Reset mid-frame abandons the frame silently; no error pulse is raised.
- Synchroniser: 2 flops. `rxs` (second flop) is the only copy of the line used by the logic. Input-to-rxs latency is 2 cycles.
- Tick generator: counter 0..DIV-1 produces a 1-cycle `tick` at DIV-1. The counter is forced to 0 on start detection so tick phase aligns with the frame.
- Bit timing: each bit spans 16 ticks, indexed 0..15. Majority of 3 samples is taken at ticks 7, 8 and 9; the decision is made at tick 9.
- FSM states and transitions:
  - IDLE: a falling edge on rxs (previous 1, current 0) → START, with tick index = 0.
  - START: at tick 9, if majority = 1 (false start) → IDLE with no error; if 0 → DATA, bit=0, at tick 15.
  - DATA: at each tick 9, shift the majority value into bit position `bit` (LSB first). After tick 15 of bit 7 → STOP.
  - STOP, majority = 1 at tick 9: commit the byte → IDLE. The return to IDLE happens mid stop bit so back-to-back frames from a slightly fast transmitter resync.
  - STOP, majority = 0 at tick 9: pulse framing_err, discard the byte → BREAK.
  - BREAK: wait until rxs = 1, then → IDLE. A held-low line (break) therefore produces exactly one framing_err.
- Commit and buffer rules:
  - Commit occurs in the cycle after the stop decision.
  - Buffer empty, or rx_valid & rx_ready in the commit cycle: load rx_data, set rx_valid=1, no overrun.
  - Buffer full with rx_ready=0: keep the old byte, drop the new one, pulse overrun_err.
  - rx_valid clears on rx_valid & rx_ready when no commit occurs in the same cycle.
  - rx_data is stable while rx_valid=1 and rx_ready=0.
- Error pulses last exactly 1 cycle and are independent of rx_ready.
- rx_ready while rx_valid=0 has no effect.

Decomposition:
- Package `uart_pkg`:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}.
  - localparam OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9.
  - Function `uart_div(clk_hz, baud)` returning the rounded divisor.
- Sub-module `uart_tick_gen` (params DIV; ports clock, reset, clear, tick). It is reused by the future TX block.

Test Plan (all with CLK_HZ=1_600_000, BAUD=100_000 → DIV=1, 16 cycles per bit):
- Idle line for 100 cycles → rx_valid, framing_err and overrun_err all stay 0.
- Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), rx_ready=1 → rx_valid pulses for 1 cycle with rx_data=0xA5. The pulse is 2+16+8*16+10 = 156 ±1 cycles after the start edge at the pin.
- 4-cycle low glitch on an idle line → START aborts as false start; no rx_valid and no framing_err.
- Send 0x3C with the stop bit driven 0, then hold the line low for 64 cycles → exactly one framing_err pulse and no rx_valid. After the line goes high, 0x81 is received correctly.
- rx_ready=0; send 0x11, then 0x22 back-to-back → rx_data stays 0x11 with rx_valid held, and overrun_err pulses once at the 0x22 commit. Raising rx_ready then yields 0x11 only.
- Assert reset for 1 cycle mid-way through data bit 4 of 0x55 → no output and no error pulses. A following 0x0F is received correctly.
- Extra coverage: rx_ready=1 in the exact commit cycle of a second byte with the buffer full → the new byte is loaded and no overrun_err pulses.
